// File: rtl/car_sensor_detector.sv
// car_sensor_detector: debounces two raw loop sensors into latched EW/NS requests,
// released on service and capped by a per-direction maximum green-hold.
module car_sensor_detector #(
    parameter int DEBOUNCE  = 4,
    parameter int MAX_GREEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       EWSensor,
    input  logic       NSSensor,
    input  logic       EWLite,
    input  logic       NSLite,
    output logic       EWCar,
    output logic       NSCar,
    output logic [1:0] EWState,
    output logic [1:0] NSState
);
    typedef enum logic [1:0] {IDLE = 2'd0, QUAL = 2'd1, REQ = 2'd2, SERVE = 2'd3} state_t;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    logic [1:0] sensor, lite, car;
    logic [1:0] state [2];
    assign sensor = {NSSensor, EWSensor};
    assign lite   = {NSLite, EWLite};
    assign EWCar   = car[0];
    assign NSCar   = car[1];
    assign EWState = state[0];
    assign NSState = state[1];
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic             sync1_q, s_q;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] dcnt_q, dcnt_d, hcnt_q, hcnt_d;
        always_comb begin
            state_d = state_q;
            dcnt_d  = dcnt_q;
            hcnt_d  = hcnt_q;
            case (state_q)
                IDLE: if (s_q) begin
                    state_d = QUAL;
                    dcnt_d  = ONE;
                end
                QUAL: if (!s_q) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DB_LAST) state_d = REQ;
                else dcnt_d = dcnt_q + ONE;
                REQ: if (lite[c]) begin
                    state_d = SERVE;
                    hcnt_d  = '0;
                end
                SERVE: begin
                    hcnt_d = (hcnt_q == HOLD_MAX) ? hcnt_q : hcnt_q + ONE;
                    if (!lite[c]) state_d = s_q ? REQ : IDLE;
                end
            endcase
        end
        always_ff @(posedge clock) begin
            if (reset) begin
                sync1_q <= 1'b0;
                s_q     <= 1'b0;
                state_q <= IDLE;
                dcnt_q  <= '0;
                hcnt_q  <= '0;
            end else begin
                sync1_q <= sensor[c];
                s_q     <= sync1_q;
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
                hcnt_q  <= hcnt_d;
            end
        end
        // request drops during service once the vehicle leaves or the hold expires
        assign car[c] = (state_q == REQ) ||
                        (state_q == SERVE && s_q && (MAX_GREEN == 0 || hcnt_q < HOLD_MAX));
        assign state[c] = state_q;
    end
endmodule

// File: tb/tb_car_sensor_detector.sv
// tb_car_sensor_detector: directed stimulus pushes expected outputs into a queue;
// a negedge monitor pops and compares {EWCar, NSCar, EWState, NSState}.
module tb_car_sensor_detector;
    logic       clock = 1'b0;
    logic       reset, EWSensor, NSSensor, EWLite, NSLite;
    logic       EWCar, NSCar;
    logic [1:0] EWState, NSState;
    typedef struct {
        logic [5:0] exp;
        string      name;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    car_sensor_detector #(.DEBOUNCE(4), .MAX_GREEN(16), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .EWSensor(EWSensor), .NSSensor(NSSensor),
        .EWLite(EWLite), .NSLite(NSLite),
        .EWCar(EWCar), .NSCar(NSCar),
        .EWState(EWState), .NSState(NSState)
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] o(input logic ec, input logic nc, input logic [1:0] es, input logic [1:0] nsv);
        return {ec, nc, es, nsv};
    endfunction

    task automatic step(input logic r, input logic ew, input logic ns, input logic ewl, input logic nsl,
                        input logic [5:0] e, input string nm);
        reset    = r;
        EWSensor = ew;
        NSSensor = ns;
        EWLite   = ewl;
        NSLite   = nsl;
        q.push_back('{e, nm});
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({EWCar, NSCar, EWState, NSState} !== e.exp) begin
                errors++;
                $display("FAIL %s: got {ewcar,nscar,ews,nss}=%b required=%b at %0t",
                         e.name, {EWCar, NSCar, EWState, NSState}, e.exp, $time);
            end
        end
    end

    initial begin
        // reset hold with EW sensor high, then full DEBOUNCE+1 latency from release
        repeat (3) step(1, 1, 0, 0, 0, o(0, 0, 0, 0), "rst_hold");
        step(0, 1, 0, 0, 0, o(0, 0, 0, 0), "rel_k");
        step(0, 1, 0, 0, 0, o(0, 0, 0, 0), "rel_k1");
        repeat (3) step(0, 1, 0, 0, 0, o(0, 0, 1, 0), "ew_qual");
        step(0, 1, 0, 0, 0, o(1, 0, 2, 0), "ew_req_k5");
        // NS glitch of 3 samples is rejected
        repeat (2) step(1, 0, 0, 0, 0, o(0, 0, 0, 0), "rst");
        step(0, 0, 1, 0, 0, o(0, 0, 0, 0), "gl_n1");
        step(0, 0, 1, 0, 0, o(0, 0, 0, 0), "gl_n2");
        step(0, 0, 1, 0, 0, o(0, 0, 0, 1), "gl_n3");
        step(0, 0, 0, 0, 0, o(0, 0, 0, 1), "gl_n4");
        step(0, 0, 0, 0, 0, o(0, 0, 0, 1), "gl_n5");
        repeat (4) step(0, 0, 0, 0, 0, o(0, 0, 0, 0), "gl_idle");
        // NS pulse of exactly DEBOUNCE samples qualifies and latches
        step(0, 0, 1, 0, 0, o(0, 0, 0, 0), "p4_1");
        step(0, 0, 1, 0, 0, o(0, 0, 0, 0), "p4_2");
        step(0, 0, 1, 0, 0, o(0, 0, 0, 1), "p4_3");
        step(0, 0, 1, 0, 0, o(0, 0, 0, 1), "p4_4");
        step(0, 0, 0, 0, 0, o(0, 0, 0, 1), "p4_5");
        repeat (4) step(0, 0, 0, 0, 0, o(0, 1, 0, 2), "p4_latched");
        // EW request latch, then service with vehicle gone
        repeat (2) step(1, 0, 0, 0, 0, o(0, 0, 0, 0), "rst");
        for (int i = 1; i <= 50; i++)
            step(0, i <= 10, 0, 0, 0,
                 i <= 2 ? o(0, 0, 0, 0) : i <= 5 ? o(0, 0, 1, 0) : o(1, 0, 2, 0), "ew_latch");
        step(0, 0, 0, 1, 0, o(0, 0, 3, 0), "ew_serve_s0");
        repeat (3) step(0, 0, 0, 1, 0, o(0, 0, 3, 0), "ew_serve_hold");
        step(0, 0, 0, 0, 0, o(0, 0, 0, 0), "ew_lite_drop");
        // max green with sensor held high
        repeat (2) step(1, 0, 0, 0, 0, o(0, 0, 0, 0), "rst");
        for (int i = 1; i <= 6; i++)
            step(0, 1, 0, 0, 0,
                 i <= 2 ? o(0, 0, 0, 0) : i <= 5 ? o(0, 0, 1, 0) : o(1, 0, 2, 0), "mg_qual");
        for (int j = 0; j < 20; j++)
            step(0, 1, 0, 1, 0, j <= 15 ? o(1, 0, 3, 0) : o(0, 0, 3, 0), "mg_serve");
        step(0, 1, 0, 0, 0, o(1, 0, 2, 0), "mg_rereq");
        step(0, 1, 0, 0, 0, o(1, 0, 2, 0), "mg_req_hold");
        // simultaneous arrival, then independent service
        repeat (2) step(1, 0, 0, 0, 0, o(0, 0, 0, 0), "rst");
        for (int i = 1; i <= 6; i++)
            step(0, 1, 1, 0, 0,
                 i <= 2 ? o(0, 0, 0, 0) : i <= 5 ? o(0, 0, 1, 1) : o(1, 1, 2, 2), "sim");
        step(0, 1, 1, 0, 1, o(1, 1, 2, 3), "ns_serve_only");
        step(0, 1, 1, 1, 1, o(1, 1, 3, 3), "both_serve");
        // reset mid-serve; restart with lites already high gives 1-cycle REQ
        step(1, 1, 1, 1, 1, o(0, 0, 0, 0), "rst_mid_serve");
        for (int i = 1; i <= 7; i++)
            step(0, 1, 1, 1, 1,
                 i <= 2 ? o(0, 0, 0, 0) : i <= 5 ? o(0, 0, 1, 1) :
                 i == 6 ? o(1, 1, 2, 2) : o(1, 1, 3, 3), "post_rst");
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
